// File: rtl/tmp_decim_pkg.sv
// tmp_decim_pkg: shared state encoding and code-width derivation for the bitstream decimator.
package tmp_decim_pkg;

    typedef enum logic [1:0] {IDLE, SETTLE, ACQ} state_e;

    function automatic int code_w(input int log2_win);
        return log2_win + 1;
    endfunction

endpackage

// File: rtl/tmp_decim_if.sv
// tmp_decim_if: valid/ready result channel carrying the temperature code.
interface tmp_decim_if #(parameter int CODE_W = tmp_decim_pkg::code_w(8));

    logic [CODE_W-1:0] code;
    logic              code_valid;
    logic              code_ready;

    modport master (output code, code_valid, input code_ready);
    modport slave (input code, code_valid, output code_ready);

endinterface

// File: rtl/tmp_decim_edge.sv
// tmp_decim_edge: turns src_n/snk toggles into a sample strobe and value, flagging simultaneous toggles.
module tmp_decim_edge (
    input  logic clk,
    input  logic src_n,
    input  logic snk,
    output logic strobe,
    output logic value,
    output logic seq_err_pulse
);

    logic src_q, snk_q, s_snk;

    // History simply follows the lines, so reset needs no special load value.
    always_ff @(posedge clk) begin
        src_q <= src_n;
        snk_q <= snk;
    end

    always_comb begin
        value         = src_n ^ src_q;
        s_snk         = snk ^ snk_q;
        strobe        = value ^ s_snk;
        seq_err_pulse = value & s_snk;
    end

endmodule

// File: rtl/tmp_decim.sv
// tmp_decim: counts ones over 2^LOG2_WIN bitstream samples and hands the count out via valid/ready.
// Define TMP_DECIM_RUNAVG_EN to push the rounded mean of the current and previous window instead.
module tmp_decim
    import tmp_decim_pkg::*;
#(
    parameter int LOG2_WIN = 8,
    parameter int SETTLE   = 4,
    parameter int CODE_W   = code_w(LOG2_WIN)
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic src_n,
    input  logic snk,
    tmp_decim_if.master res,
    output logic overrun,
    output logic seq_err,
    output logic busy
);

    localparam int SW = SETTLE > 0 ? $clog2(SETTLE + 1) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE > 0 ? SETTLE - 1 : 0);

    state_e              state_q, state_d;
    logic                strobe, value, seq_err_pulse, push;
    logic [SW-1:0]       settle_cnt_q, settle_cnt_d;
    logic [LOG2_WIN-1:0] samp_q, samp_d;
    logic [CODE_W-1:0]   ones_q, ones_d, result, pushed, code_q;
    logic                code_valid_q, overrun_q, seq_err_q;

    tmp_decim_edge u_edge (
        .clk(clk),
        .src_n(src_n),
        .snk(snk),
        .strobe(strobe),
        .value(value),
        .seq_err_pulse(seq_err_pulse)
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else state_q <= state_d;
    end

    always_comb begin
        state_d = !en ? IDLE
                : state_q == IDLE ? (SETTLE > 0 ? tmp_decim_pkg::SETTLE : ACQ)
                : (state_q == tmp_decim_pkg::SETTLE && strobe && settle_cnt_q == SETTLE_LAST) ? ACQ
                : state_q;
    end

    always_comb begin
        busy = state_q != IDLE;
    end

    // samp wraps to zero on the completing strobe, so the next window starts at once.
    always_comb begin
        push         = state_q == ACQ && en && strobe && &samp_q;
        result       = ones_q + CODE_W'(value);
        settle_cnt_d = state_q == tmp_decim_pkg::SETTLE ? settle_cnt_q + SW'(strobe) : '0;
        samp_d       = state_q == ACQ && en ? samp_q + LOG2_WIN'(strobe) : '0;
        ones_d       = state_q == ACQ && en && !push ? ones_q + CODE_W'(strobe & value) : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            settle_cnt_q <= '0;
            samp_q       <= '0;
            ones_q       <= '0;
        end else begin
            settle_cnt_q <= settle_cnt_d;
            samp_q       <= samp_d;
            ones_q       <= ones_d;
        end
    end

`ifdef TMP_DECIM_RUNAVG_EN
    logic [CODE_W-1:0] prev_q;
    logic              have_prev_q;
    logic [CODE_W:0]   avg;

    assign avg    = ({1'b0, result} + {1'b0, prev_q} + (CODE_W + 1)'(1)) >> 1;
    assign pushed = have_prev_q ? avg[CODE_W-1:0] : result;

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q      <= '0;
            have_prev_q <= 1'b0;
        end else if (push) begin
            prev_q      <= result;
            have_prev_q <= 1'b1;
        end
    end
`else
    assign pushed = result;
`endif

    // A push always wins over an accept; an unaccepted result is overwritten and flagged.
    always_ff @(posedge clk) begin
        if (reset) begin
            code_q       <= '0;
            code_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
            seq_err_q    <= 1'b0;
        end else begin
            seq_err_q <= seq_err_q | seq_err_pulse;
            if (push) begin
                code_q       <= pushed;
                code_valid_q <= 1'b1;
                overrun_q    <= overrun_q | (code_valid_q & ~res.code_ready);
            end else if (code_valid_q && res.code_ready) begin
                code_valid_q <= 1'b0;
            end
        end
    end

    assign res.code       = code_q;
    assign res.code_valid = code_valid_q;
    assign overrun        = overrun_q;
    assign seq_err        = seq_err_q;

endmodule

// File: tb/tb_tmp_decim.sv
// tb_tmp_decim: directed bench for tmp_decim with LOG2_WIN=4, SETTLE=2.
module tb_tmp_decim;

    localparam int LW = 4;
    localparam int ST = 2;
    localparam int CW = 5;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic en = 1'b0;
    logic src_n = 1'b0;
    logic snk = 1'b0;
    logic overrun, seq_err, busy;
    int   n_checks = 0;
    int   n_err = 0;
    int   prev_m = 0;
    int   last_exp = 0;
    bit   first_m = 1'b1;

    tmp_decim_if #(.CODE_W(CW)) bus ();

    tmp_decim #(.LOG2_WIN(LW), .SETTLE(ST)) dut (
        .clk(clk),
        .reset(reset),
        .en(en),
        .src_n(src_n),
        .snk(snk),
        .res(bus.master),
        .overrun(overrun),
        .seq_err(seq_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Expected pushed code for a window whose raw ones count is raw.
    function automatic int exp_code(input int raw);
        int r;
`ifdef TMP_DECIM_RUNAVG_EN
        r = first_m ? raw : (raw + prev_m + 1) / 2;
        prev_m = raw;
        first_m = 1'b0;
`else
        r = raw;
`endif
        return r;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic tog(input bit one);
        @(negedge clk);
        if (one) src_n = ~src_n;
        else snk = ~snk;
    endtask

    task automatic win(input int n_ones, input int n);
        for (int i = 0; i < n; i++) tog(i < n_ones);
    endtask

    task automatic push_chk(input string tag, input int raw);
        last_exp = exp_code(raw);
        chk(tag, 32'(bus.code), 32'(last_exp));
    endtask

    task automatic reset_chk(input string tag);
        chk({tag, "_code"}, 32'(bus.code), 0);
        chk({tag, "_valid"}, 32'(bus.code_valid), 0);
        chk({tag, "_overrun"}, 32'(overrun), 0);
        chk({tag, "_seq_err"}, 32'(seq_err), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
    endtask

    initial begin
        bus.code_ready = 1'b0;
        tick();
        tick();
        reset_chk("rst");
        reset = 1'b0;
        en = 1'b1;
        tick();
        chk("busy_settle", 32'(busy), 1);
        tog(1'b1);
        tog(1'b0);
        win(10, 16);
        tick();
        push_chk("code_10", 10);
        chk("valid_10", 32'(bus.code_valid), 1);
        chk("busy_10", 32'(busy), 1);
        chk("ovr_10", 32'(overrun), 0);
        bus.code_ready = 1'b1;
        tick();
        chk("accept_valid", 32'(bus.code_valid), 0);
        chk("accept_code", 32'(bus.code), 32'(last_exp));
        win(16, 16);
        tick();
        push_chk("all_ones", 16);
        win(0, 16);
        tick();
        push_chk("all_zero", 0);
        tick();
        chk("drain_valid", 32'(bus.code_valid), 0);
        bus.code_ready = 1'b0;
        win(7, 16);
        tick();
        push_chk("win7", 7);
        chk("ovr_7", 32'(overrun), 0);
        win(9, 16);
        tick();
        push_chk("win9", 9);
        chk("valid_9", 32'(bus.code_valid), 1);
        chk("ovr_9", 32'(overrun), 1);
        bus.code_ready = 1'b1;
        tick();
        bus.code_ready = 1'b0;
        chk("ovr_accept_valid", 32'(bus.code_valid), 0);
        chk("ovr_sticky", 32'(overrun), 1);
        chk("ovr_accept_code", 32'(bus.code), 32'(last_exp));
        win(3, 5);
        @(negedge clk);
        src_n = ~src_n;
        snk = ~snk;
        tick();
        chk("seq_err", 32'(seq_err), 1);
        chk("seq_nopush_valid", 32'(bus.code_valid), 0);
        win(4, 11);
        tick();
        push_chk("seq_win", 7);
        chk("seq_valid", 32'(bus.code_valid), 1);
        bus.code_ready = 1'b1;
        tick();
        bus.code_ready = 1'b0;
        win(8, 8);
        @(negedge clk);
        en = 1'b0;
        tick();
        chk("abort_busy", 32'(busy), 0);
        chk("abort_code", 32'(bus.code), 32'(last_exp));
        chk("abort_valid", 32'(bus.code_valid), 0);
        en = 1'b1;
        tog(1'b1);
        tog(1'b1);
        win(5, 16);
        tick();
        push_chk("resettle", 5);
        chk("seq_sticky", 32'(seq_err), 1);
        win(6, 6);
        @(negedge clk);
        reset = 1'b1;
        tick();
        reset_chk("midrst");
        reset = 1'b0;
        first_m = 1'b1;
        prev_m = 0;
        tog(1'b0);
        tog(1'b0);
        win(10, 16);
        tick();
        push_chk("post_rst_a", 10);
        bus.code_ready = 1'b1;
        win(13, 16);
        tick();
        push_chk("post_rst_b", 13);
        chk("post_rst_ovr", 32'(overrun), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
